// File: rtl/gat_pkg.sv
// Constants shared by the GAT accelerator and its host-side BRAM loader,
// plus the loader FSM state encoding.
package gat_pkg;

  localparam int GAT_TOP_WIDTH         = 32;
  localparam int GAT_H_DATA_DEPTH      = 242101;
  localparam int GAT_NODE_INFO_DEPTH   = 13264;
  localparam int GAT_WEIGHT_DEPTH      = 22928;
  localparam int GAT_NEW_FEATURE_DEPTH = 43328;
  localparam int GAT_FEAT_RD_LATENCY   = 2;

  localparam int GAT_H_DATA_ADDR_W      = $clog2(GAT_H_DATA_DEPTH);
  localparam int GAT_NODE_INFO_ADDR_W   = $clog2(GAT_NODE_INFO_DEPTH);
  localparam int GAT_WEIGHT_ADDR_W      = $clog2(GAT_WEIGHT_DEPTH);
  localparam int GAT_NEW_FEATURE_ADDR_W = $clog2(GAT_NEW_FEATURE_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_H   = 3'd1,
    ST_LOAD_NI  = 3'd2,
    ST_LOAD_W   = 3'd3,
    ST_WAIT_GAT = 3'd4,
    ST_RD_ADDR  = 3'd5,
    ST_RD_WAIT  = 3'd6,
    ST_RD_OUT   = 3'd7
  } loader_state_t;

endpackage

// File: rtl/gat_bram_region_writer.sv
// One BRAM write region: counts accepted words, registers data and byte address,
// and issues a one-cycle write strobe per word; done rises with the final strobe.
module gat_bram_region_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              en_i,
  input  logic              hs_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              last_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] din_o,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W+1:0] addra_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              stb_q, stb_d;
  logic              done_q, done_d;
  logic              take_s;

  assign take_s  = en_i && hs_i;
  assign last_o  = take_s && (idx_q == (len_q - ONE));
  assign empty_o = (len_q == '0);

  // A zero-length region is already done the moment it is started.
  always_comb begin
    len_d  = len_q;
    idx_d  = idx_q;
    din_d  = din_q;
    addr_d = addr_q;
    stb_d  = 1'b0;
    done_d = done_q;
    if (start_i) begin
      len_d  = len_i;
      idx_d  = '0;
      done_d = (len_i == '0);
    end else if (take_s) begin
      din_d  = data_i;
      addr_d = {idx_q[ADDR_W-1:0], 2'b00};
      stb_d  = 1'b1;
      if (last_o) begin
        idx_d  = '0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + ONE;
      end
    end else begin
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      idx_q  <= '0;
      din_q  <= '0;
      addr_q <= '0;
      stb_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      idx_q  <= idx_d;
      din_q  <= din_d;
      addr_q <= addr_d;
      stb_q  <= stb_d;
      done_q <= done_d;
    end
  end

  assign din_o   = din_q;
  assign ena_o   = stb_q;
  assign wea_o   = stb_q;
  assign addra_o = addr_q;
  assign done_o  = done_q;

endmodule

// File: rtl/gat_bram_loader.sv
// Host-side BRAM master for the GAT accelerator: streams DMA words into the
// H-data, node-info and weight BRAMs, then reads the new-feature BRAM back out.
module gat_bram_loader
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH          = GAT_TOP_WIDTH,
  parameter int H_DATA_DEPTH       = GAT_H_DATA_DEPTH,
  parameter int NODE_INFO_DEPTH    = GAT_NODE_INFO_DEPTH,
  parameter int WEIGHT_DEPTH       = GAT_WEIGHT_DEPTH,
  parameter int NEW_FEATURE_DEPTH  = GAT_NEW_FEATURE_DEPTH,
  parameter int FEAT_RD_LATENCY    = GAT_FEAT_RD_LATENCY,
  parameter int H_DATA_ADDR_W      = $clog2(H_DATA_DEPTH),
  parameter int NODE_INFO_ADDR_W   = $clog2(NODE_INFO_DEPTH),
  parameter int WEIGHT_ADDR_W      = $clog2(WEIGHT_DEPTH),
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [H_DATA_ADDR_W:0]        h_data_words,
  input  logic [NODE_INFO_ADDR_W:0]     node_info_words,
  input  logic [WEIGHT_ADDR_W:0]        wgt_words,
  input  logic [NEW_FEATURE_ADDR_W:0]   feat_words,
  input  logic [TOP_WIDTH-1:0]          s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [TOP_WIDTH-1:0]          h_data_bram_din,
  output logic                          h_data_bram_ena,
  output logic                          h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]          h_node_info_bram_din,
  output logic                          h_node_info_bram_ena,
  output logic                          h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]          wgt_bram_din,
  output logic                          wgt_bram_ena,
  output logic                          wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
  output logic                          h_data_bram_load_done,
  output logic                          h_node_info_bram_load_done,
  output logic                          wgt_bram_load_done,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [TOP_WIDTH-1:0]          feat_bram_dout,
  output logic [TOP_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic                          load_err
);

  localparam logic [NEW_FEATURE_ADDR_W:0] FEAT_ONE = {{NEW_FEATURE_ADDR_W{1'b0}}, 1'b1};
  localparam logic [1:0]                  LAT_LAST = 2'(FEAT_RD_LATENCY - 1);

  loader_state_t state_q, state_d;

  logic start_acc_s, s_hs_s, m_hs_s, final_word_s, wait_done_s, rd_last_s;
  logic h_last_s, ni_last_s, w_last_s;
  logic h_empty_s, ni_empty_s, w_empty_s;

  logic                            s_tready_q, s_tready_d;
  logic                            busy_q, busy_d;
  logic                            load_err_q, load_err_d;
  logic [NEW_FEATURE_ADDR_W:0]     feat_len_q, feat_len_d;
  logic [NEW_FEATURE_ADDR_W:0]     rd_idx_q, rd_idx_d;
  logic [1:0]                      wait_cnt_q, wait_cnt_d;
  logic [NEW_FEATURE_ADDR_W+1:0]   addrb_q, addrb_d;
  logic [TOP_WIDTH-1:0]            m_tdata_q, m_tdata_d;
  logic                            m_tvalid_q, m_tvalid_d;
  logic                            m_tlast_q, m_tlast_d;

  assign start_acc_s = start && (state_q == ST_IDLE);
  assign s_hs_s      = s_axis_tvalid && s_tready_q;
  assign m_hs_s      = (state_q == ST_RD_OUT) && m_axis_tready;
  assign wait_done_s = (state_q == ST_RD_WAIT) && (wait_cnt_q == LAT_LAST);
  assign rd_last_s   = (rd_idx_q == (feat_len_q - FEAT_ONE));
  // The overall last word is the final word of the last non-empty region.
  assign final_word_s = (h_last_s && ni_empty_s && w_empty_s) ||
                        (ni_last_s && w_empty_s) || w_last_s;

  gat_bram_region_writer #(.DATA_W(TOP_WIDTH), .ADDR_W(H_DATA_ADDR_W)) u_h_writer (
    .clk(clk), .rst_n(rst_n), .start_i(start_acc_s), .len_i(h_data_words),
    .en_i(state_q == ST_LOAD_H), .hs_i(s_hs_s), .data_i(s_axis_tdata),
    .last_o(h_last_s), .empty_o(h_empty_s), .din_o(h_data_bram_din),
    .ena_o(h_data_bram_ena), .wea_o(h_data_bram_wea), .addra_o(h_data_bram_addra),
    .done_o(h_data_bram_load_done)
  );

  gat_bram_region_writer #(.DATA_W(TOP_WIDTH), .ADDR_W(NODE_INFO_ADDR_W)) u_ni_writer (
    .clk(clk), .rst_n(rst_n), .start_i(start_acc_s), .len_i(node_info_words),
    .en_i(state_q == ST_LOAD_NI), .hs_i(s_hs_s), .data_i(s_axis_tdata),
    .last_o(ni_last_s), .empty_o(ni_empty_s), .din_o(h_node_info_bram_din),
    .ena_o(h_node_info_bram_ena), .wea_o(h_node_info_bram_wea),
    .addra_o(h_node_info_bram_addra), .done_o(h_node_info_bram_load_done)
  );

  gat_bram_region_writer #(.DATA_W(TOP_WIDTH), .ADDR_W(WEIGHT_ADDR_W)) u_w_writer (
    .clk(clk), .rst_n(rst_n), .start_i(start_acc_s), .len_i(wgt_words),
    .en_i(state_q == ST_LOAD_W), .hs_i(s_hs_s), .data_i(s_axis_tdata),
    .last_o(w_last_s), .empty_o(w_empty_s), .din_o(wgt_bram_din),
    .ena_o(wgt_bram_ena), .wea_o(wgt_bram_wea), .addra_o(wgt_bram_addra),
    .done_o(wgt_bram_load_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Empty regions are skipped without spending a cycle in their state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (h_data_words != '0)         state_d = ST_LOAD_H;
          else if (node_info_words != '0) state_d = ST_LOAD_NI;
          else if (wgt_words != '0)       state_d = ST_LOAD_W;
          else                            state_d = ST_WAIT_GAT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_H: begin
        if (h_last_s) begin
          if (!ni_empty_s)     state_d = ST_LOAD_NI;
          else if (!w_empty_s) state_d = ST_LOAD_W;
          else                 state_d = ST_WAIT_GAT;
        end else begin
          state_d = ST_LOAD_H;
        end
      end
      ST_LOAD_NI: begin
        if (ni_last_s) begin
          if (!w_empty_s) state_d = ST_LOAD_W;
          else            state_d = ST_WAIT_GAT;
        end else begin
          state_d = ST_LOAD_NI;
        end
      end
      ST_LOAD_W: begin
        if (w_last_s) state_d = ST_WAIT_GAT;
        else          state_d = ST_LOAD_W;
      end
      ST_WAIT_GAT: begin
        if (gat_ready) begin
          if (feat_len_q == '0) state_d = ST_IDLE;
          else                  state_d = ST_RD_ADDR;
        end else begin
          state_d = ST_WAIT_GAT;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (wait_done_s) state_d = ST_RD_OUT;
        else             state_d = ST_RD_WAIT;
      end
      ST_RD_OUT: begin
        if (m_axis_tready) begin
          if (rd_last_s) state_d = ST_IDLE;
          else           state_d = ST_RD_ADDR;
        end else begin
          state_d = ST_RD_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready_d = (state_d == ST_LOAD_H) || (state_d == ST_LOAD_NI) || (state_d == ST_LOAD_W);
    busy_d     = (state_d != ST_IDLE);
    feat_len_d = start_acc_s ? feat_words : feat_len_q;

    if (start_acc_s) begin
      load_err_d = 1'b0;
    end else if (s_hs_s && (s_axis_tlast != final_word_s)) begin
      load_err_d = 1'b1;
    end else begin
      load_err_d = load_err_q;
    end

    if (start_acc_s) begin
      rd_idx_d = '0;
    end else if (m_hs_s) begin
      rd_idx_d = rd_idx_q + FEAT_ONE;
    end else begin
      rd_idx_d = rd_idx_q;
    end

    // The read address is launched on entry to RD_ADDR and held until the next one.
    if (state_d == ST_RD_ADDR) begin
      addrb_d = {rd_idx_d[NEW_FEATURE_ADDR_W-1:0], 2'b00};
    end else begin
      addrb_d = addrb_q;
    end

    wait_cnt_d = (state_q == ST_RD_WAIT) ? (wait_cnt_q + 2'd1) : 2'd0;
    m_tdata_d  = wait_done_s ? feat_bram_dout : m_tdata_q;
    m_tvalid_d = (state_d == ST_RD_OUT);
    m_tlast_d  = (state_d == ST_RD_OUT) && rd_last_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
      load_err_q <= 1'b0;
      feat_len_q <= '0;
      rd_idx_q   <= '0;
      wait_cnt_q <= 2'd0;
      addrb_q    <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      s_tready_q <= s_tready_d;
      busy_q     <= busy_d;
      load_err_q <= load_err_d;
      feat_len_q <= feat_len_d;
      rd_idx_q   <= rd_idx_d;
      wait_cnt_q <= wait_cnt_d;
      addrb_q    <= addrb_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign s_axis_tready   = s_tready_q;
  assign busy            = busy_q;
  assign load_err        = load_err_q;
  assign feat_bram_addrb = addrb_q;
  assign m_axis_tdata    = m_tdata_q;
  assign m_axis_tvalid   = m_tvalid_q;
  assign m_axis_tlast    = m_tlast_q;

endmodule

// File: doc/gat_bram_loader.md
Name: gat_bram_loader

Overview:
Host-side master for the GAT accelerator's BRAM interface. It takes one AXI-Stream of 32-bit words from the DMA and writes it, in order, into the H-data, node-info and weight BRAM write ports using byte addresses. It raises the matching load-done levels, waits for gat_ready, then reads the new-feature BRAM through its byte-addressed read port and returns the result as an AXI-Stream.

Parameters:
TOP_WIDTH, 32, data width of the stream and BRAM ports
H_DATA_DEPTH, 242101, H sparse-data BRAM depth in words
NODE_INFO_DEPTH, 13264, node-info BRAM depth in words
WEIGHT_DEPTH, 22928, weight BRAM depth in words
NEW_FEATURE_DEPTH, 43328, new-feature BRAM depth in words
FEAT_RD_LATENCY, 2, cycles from feat_bram_addrb to valid feat_bram_dout (1..3)
H_DATA_ADDR_W / NODE_INFO_ADDR_W / WEIGHT_ADDR_W / NEW_FEATURE_ADDR_W, $clog2 of each depth, word-address widths

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
h_data_words  in  H_DATA_ADDR_W+1  number of H-data words to load
node_info_words  in  NODE_INFO_ADDR_W+1  number of node-info words to load
wgt_words  in  WEIGHT_ADDR_W+1  number of weight words to load
feat_words  in  NEW_FEATURE_ADDR_W+1  number of feature words to read back
s_axis_tdata  in  TOP_WIDTH  load stream data
s_axis_tvalid  in  1  load stream valid
s_axis_tlast  in  1  end of load stream
s_axis_tready  out  1  load stream ready
h_data_bram_din / _ena / _wea / _addra  out  TOP_WIDTH/1/1/H_DATA_ADDR_W+2  H-data write port
h_node_info_bram_din / _ena / _wea / _addra  out  TOP_WIDTH/1/1/NODE_INFO_ADDR_W+2  node-info write port
wgt_bram_din / _ena / _wea / _addra  out  TOP_WIDTH/1/1/WEIGHT_ADDR_W+2  weight write port
h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1 each  load-complete levels
gat_ready  in  1  accelerator finished
feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  feature read byte address
feat_bram_dout  in  TOP_WIDTH  feature read data
m_axis_tdata  out  TOP_WIDTH  result stream data
m_axis_tvalid  out  1  result stream valid
m_axis_tlast  out  1  last result word
m_axis_tready  in  1  result stream ready
busy  out  1  high when not in IDLE
load_err  out  1  sticky tlast-mismatch flag; cleared on accepted start

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. A reset mid-operation aborts immediately; no further BRAM strobes are issued.
- States: IDLE -> LOAD_H -> LOAD_NI -> LOAD_W -> WAIT_GAT -> RD_ADDR -> RD_WAIT -> RD_OUT -> back to RD_ADDR, or to IDLE after the last word.
- start: the four length inputs are latched, all load_done outputs and load_err are cleared, and the FSM enters LOAD_H. start is ignored when not in IDLE.
- Load states:
  - s_axis_tready is 1.
  - Each handshake (tvalid & tready) produces, on the next cycle, a single-cycle ena=wea=1 on the active region's port.
  - din is the registered tdata. addra = {word_idx, 2'b00}, so bits [1:0] are always 0.
  - word_idx resets to 0 on each region entry and counts to len-1. The next region's first word is accepted the cycle after the previous region's last word, with no bubble.
- A region with length 0 is skipped in 0 cycles.
- Each region's load_done rises with that region's final write strobe. It stays high until the next accepted start.
- tlast check: load_err is set if tlast=1 on any word other than the overall last loaded word, or tlast=0 on that last word. Loading continues regardless.
- If all load lengths are 0, the FSM goes straight to WAIT_GAT and all three load_done outputs rise together.
- WAIT_GAT: tready is 0. The FSM moves to RD_ADDR on the first cycle gat_ready=1. If feat_words=0 it returns to IDLE instead.
- Readback:
  - RD_ADDR drives feat_bram_addrb = {rd_idx, 2'b00}, which holds until the next RD_ADDR.
  - RD_WAIT counts FEAT_RD_LATENCY cycles, then captures feat_bram_dout into m_axis_tdata.
  - RD_OUT asserts m_axis_tvalid, with m_axis_tlast = (rd_idx == feat_words-1).
  - tdata, tvalid and tlast hold stable until m_axis_tready is sampled high. tvalid must not drop without a handshake.
- Throughput: at most one word per FEAT_RD_LATENCY+2 cycles; this is acceptable.
- Counters use modular width. Lengths larger than the depth parameter are the caller's error; addresses simply wrap.

Decomposition:
- Package gat_pkg holds:
  - the depth constants and derived address widths shared with the accelerator top;
  - an enum loader_state_t for the FSM states.
- One natural sub-module: gat_bram_region_writer, instantiated three times. It owns a word counter, registers din/addr, generates the strobe and drives done. The region enables are chained from the FSM.

Test Plan:
- Lengths 3/2/2, 7 words streamed with tvalid always high and tlast on word 7 -> H writes at addra 0,4,8; NI at 0,4; W at 0,4; done levels rise in order; load_err=0; tready is never low during load.
- Same stream with tvalid toggling 1,0,1,0 -> identical write sequence with no strobe on idle cycles; din matches tdata in order.
- h_data_words=0, lengths 0/2/1 -> no H strobe; h_data_bram_load_done rises in the start+1 cycle; NI gets the first word.
- tlast on word 2 of 7 -> load_err=1 and stays 1; all 7 writes still occur; the next start clears it.
- feat_words=4, FEAT_RD_LATENCY=2, BRAM model returning addr*3, m_axis_tready low for 3 cycles on word 1 -> addrb 0,4,8,12; data 0,12,24,36 held stable under stall; tlast only on the 4th word; FSM returns to IDLE.
- rst_n asserted mid LOAD_NI -> all strobes, done levels and tready are 0 immediately; after release, a new start loads from address 0.
